fifo_stream_drain: RTL and testbench
====================================

Name: fifo_stream_drain

Overview:
- Downstream consumer of the synchronous byte FIFO (`fifo`).
- Pops words using the FIFO's rd_en/empty/data_out interface and re-times them into a 3-entry output buffer.
- Presents the words as a valid/ready stream, with packet framing (m_last every PKT_LEN beats) and a running beat count.
- Sits between the FIFO and any backpressuring sink (serializer, bus master).

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data.
PKT_LEN, 4, beats per packet; m_last marks beat PKT_LEN-1. Legal range 1..256.
CNT_WIDTH, 16, width of word_count.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset); release is synchronous to clk by the system.
enable  input  1  1 = allow new FIFO reads.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO read request.
fifo_data  input  DATA_WIDTH  FIFO data_out; valid in the cycle after a read request.
m_valid  output  1  stream data valid.
m_ready  input  1  sink accepts the current beat.
m_data  output  DATA_WIDTH  stream data.
m_last  output  1  final beat of packet.
word_count  output  CNT_WIDTH  total accepted beats since reset.
busy  output  1  data in flight or buffered.

Behaviour:
- Reset (rst=0): asynchronously clear buffer, occupancy, inflight flag, beat counter and word_count.
  - Outputs forced: m_valid=0, m_data=0, m_last=0, word_count=0, busy=0.
  - fifo_rd_en=0 while rst=0, regardless of other inputs.
- Read issue (combinational): fifo_rd_en = rst & enable & !fifo_empty & ((buf_cnt + inflight) < 3).
  - buf_cnt: registered occupancy, 0..3.
  - inflight: registered copy of last cycle's fifo_rd_en.
  - No combinational path from m_ready to fifo_rd_en.
- Capture: when inflight=1, fifo_data is written into the buffer tail at the next edge. fifo_data is ignored when inflight=0 (the FIFO drives X then).
- Latency: fifo_rd_en high in cycle N → beat visible on m_data/m_valid in cycle N+2 when the buffer was empty.
- Buffer: 3-entry circular buffer, strict FIFO order.
  - m_valid = (buf_cnt != 0). m_data = head entry.
  - Pop on m_valid & m_ready. Push on inflight.
  - Simultaneous push and pop: buf_cnt unchanged.
  - Overflow is impossible by the credit rule; verification asserts buf_cnt <= 3 always.
- Throughput: with m_ready=1 and FIFO non-empty, one beat per cycle sustained.
- Stream rules: while m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid stays 1.
- Framing: beat_cnt (0..PKT_LEN-1) increments on each accepted beat and wraps to 0 after PKT_LEN-1.
  - m_last = m_valid & (beat_cnt == PKT_LEN-1).
  - PKT_LEN=1: m_last=1 on every valid beat.
- word_count: +1 per accepted beat, wraps modulo 2^CNT_WIDTH, no saturation.
- enable deassert: no new reads. An in-flight word is still captured, and buffered words continue to drain. Packet position is retained.
- fifo_empty rising mid-stream: reads stop; buffered and in-flight data drain normally.
- busy = (buf_cnt != 0) | inflight.
- Reset mid-operation: buffered and in-flight words are discarded and beat_cnt restarts at 0. A word popped from the FIFO in the cycle of reset is lost; this is accepted behaviour.

Test Plan:
1. Reset: rst=0 with enable=1, fifo_empty=0, m_ready=1 → fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, word_count=0, busy=0. Assert rst=0 mid-cycle → outputs clear without waiting for a clk edge.
2. Streaming: FIFO model preloaded with 0x10..0x17, enable=1, m_ready=1 → fifo_rd_en high from the first cycle after reset release; m_valid first high 2 cycles later; 8 consecutive beats 0x10..0x17; m_last on 0x13 and 0x17; word_count=8; busy=0 afterwards.
3. Backpressure: same preload, m_ready=0 → exactly 3 reads issued, then fifo_rd_en=0; m_data holds 0x10. Raise m_ready → beats 0x10..0x17 in order with no gap after the first, no loss, no duplication.
4. Empty/enable gating: fifo_empty toggles every 2 cycles, and enable drops for 5 cycles while inflight=1 → no fifo_rd_en while empty=1 or enable=0; the in-flight word still emerges; output order matches push order.
5. Reset mid-packet: reset after beat 2 of a packet, then stream 0x20..0x23 → word_count restarts at 0; m_last on 0x23 (4th beat after reset).
6. Wrap: CNT_WIDTH=4, PKT_LEN=1, stream 17 beats → word_count=1; m_last high on all 17 beats.

Source files
------------

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a synchronous FIFO into a 3-entry buffer and presents it as a
// framed valid/ready stream with a running beat count.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  logic [DATA_WIDTH-1:0] buf_mem [3];
  logic [1:0] head, tail, buf_cnt;
  logic inflight, pop;
  logic [BW-1:0] beat_cnt;
  // a read is only issued when a slot is guaranteed for it, counting the word still in flight
  assign fifo_rd_en = rst & enable & ~fifo_empty & (({1'b0, buf_cnt} + {2'b0, inflight}) < 3'd3);
  assign m_valid = buf_cnt != 2'd0;
  assign m_data = buf_mem[head];
  assign m_last = m_valid & (beat_cnt == LAST_BEAT);
  assign busy = m_valid | inflight;
  assign pop = m_valid & m_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      buf_mem <= '{default: '0};
      head <= '0;
      tail <= '0;
      buf_cnt <= '0;
      inflight <= 1'b0;
      beat_cnt <= '0;
      word_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        buf_mem[tail] <= fifo_data;
        tail <= tail == 2'd2 ? 2'd0 : tail + 2'd1;
      end
      if (pop) begin
        head <= head == 2'd2 ? 2'd0 : head + 2'd1;
        beat_cnt <= beat_cnt == LAST_BEAT ? '0 : beat_cnt + BW'(1);
        word_count <= word_count + CNT_WIDTH'(1);
      end
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
    end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: scoreboard bench; a FIFO model feeds two DUTs (default and a
// PKT_LEN=1/CNT_WIDTH=4 variant) and monitors compare every accepted beat against expectations.
module tb_fifo_stream_drain;
  localparam int PKT = 4;
  typedef struct { logic [7:0] d; logic l; logic [15:0] c; } exp_t;
  logic clk = 0, rst, enable, m_ready, force_e;
  logic empty, rd_en, m_valid, m_last, busy;
  logic [7:0] fdata, m_data;
  logic [15:0] wc;
  logic empty_w, rd_w, v_w, l_w, busy_w;
  logic [7:0] fdata_w, d_w;
  logic [3:0] wc_w;
  logic [7:0] fq[$], fq_w[$];
  exp_t exp_q[$], exp_w[$], e;
  int pushed = 0, popped = 0, pushed_w = 0, popped_w = 0;
  int pidx = 0, pidx_w = 0, rd_n = 0, acc_n = 0, n_chk = 0, n_fail = 0;
  logic hold_v = 0, hold_l;
  logic [7:0] hold_d;

  always #5 clk = ~clk;

  fifo_stream_drain dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty), .fifo_rd_en(rd_en),
    .fifo_data(fdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .word_count(wc), .busy(busy));

  fifo_stream_drain #(.PKT_LEN(1), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty_w), .fifo_rd_en(rd_w),
    .fifo_data(fdata_w), .m_valid(v_w), .m_ready(m_ready), .m_data(d_w),
    .m_last(l_w), .word_count(wc_w), .busy(busy_w));

  assign empty = force_e | (pushed == popped);
  assign empty_w = pushed_w == popped_w;

  // FIFO model: data appears the cycle after a read, garbage otherwise
  always @(posedge clk) begin
    if (rd_en && fq.size() != 0) begin fdata <= fq.pop_front(); popped <= popped + 1; end
    else fdata <= 8'($urandom);
    if (rd_w && fq_w.size() != 0) begin fdata_w <= fq_w.pop_front(); popped_w <= popped_w + 1; end
    else fdata_w <= 8'($urandom);
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, want, $time);
    end
  endtask

  task automatic push_m(input logic [7:0] d);
    fq.push_back(d);
    pushed++;
    exp_q.push_back('{d, (pidx % PKT) == PKT - 1, 16'(pidx)});
    pidx++;
  endtask

  task automatic push_w(input logic [7:0] d);
    fq_w.push_back(d);
    pushed_w++;
    exp_w.push_back('{d, 1'b1, 16'(pidx_w % 16)});
    pidx_w++;
  endtask

  always @(negedge clk) begin
    if (!rst) hold_v = 0;
    else begin
      chk("rd_gate", 32'(rd_en & (empty | ~enable)), 0);
      if (rd_en) rd_n++;
      if (hold_v) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(hold_d));
        chk("hold_last", 32'(m_last), 32'(hold_l));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_data), 32'(e.d));
          chk("beat_last", 32'(m_last), 32'(e.l));
          chk("beat_count", 32'(wc), 32'(e.c));
        end
        acc_n++;
      end
      chk("credit", 32'((rd_n - acc_n) <= 3), 1);
      hold_v = m_valid & ~m_ready;
      hold_d = m_data;
      hold_l = m_last;
      if (v_w && m_ready) begin
        if (exp_w.size() == 0) chk("w_beat_unexpected", 1, 0);
        else begin
          e = exp_w.pop_front();
          chk("w_beat_data", 32'(d_w), 32'(e.d));
          chk("w_beat_last", 32'(l_w), 32'(e.l));
          chk("w_beat_count", 32'(wc_w), 32'(e.c));
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp_w.size() != 0) && t < 500) begin @(posedge clk); t++; end
    chk("drain_done", 32'(exp_q.size() + exp_w.size()), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_busy_w", 32'(busy_w), 0);
    chk("reads_eq_beats", 32'(rd_n - acc_n), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, t, drop_i;
    logic dropped, last_rd;
    rst = 0; enable = 1; m_ready = 1; force_e = 0;
    for (int i = 0; i < 8; i++) push_m(8'h10 + 8'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_count", 32'(wc), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #2 rst = 1;
    @(negedge clk); chk("first_rd", 32'(rd_en), 1);
    @(negedge clk); chk("lat_n1", 32'(m_valid), 0);
    @(negedge clk); chk("lat_n2", 32'(m_valid), 1); chk("first_data", 32'(m_data), 32'h10);
    for (int i = 0; i < 7; i++) begin @(negedge clk); chk("stream_gap", 32'(m_valid), 1); end
    drain();
    chk("count8", 32'(wc), 8);
    // backpressure: credits must stop reads at three words
    @(posedge clk); #2 m_ready = 0;
    for (int i = 0; i < 8; i++) push_m(8'h10 + 8'(i));
    repeat (10) @(negedge clk);
    chk("bp_reads", 32'(rd_n - acc_n), 3);
    chk("bp_rd_off", 32'(rd_en), 0);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_head", 32'(m_data), 32'h10);
    @(posedge clk); #2 m_ready = 1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); chk("bp_gap", 32'(m_valid), 1); end
    drain();
    chk("count16", 32'(wc), 16);
    // empty toggling, random ready, enable dropped while a read is in flight
    @(posedge clk); #2;
    for (int i = 0; i < 12; i++) push_m(8'($urandom));
    dropped = 0; drop_i = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk) last_rd = rd_en;
      @(posedge clk); #2;
      m_ready = 1'($urandom);
      if (i % 2 == 1) force_e = ~force_e;
      if (!dropped && i >= 4 && last_rd) begin enable = 0; dropped = 1; drop_i = i; end
      else if (dropped && !enable && i == drop_i + 5) enable = 1;
    end
    chk("drop_seen", 32'(dropped), 1);
    force_e = 0; enable = 1; m_ready = 1;
    drain();
    chk("count28", 32'(wc), 28);
    // reset two beats into a packet
    base = acc_n;
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++) push_m(8'h30 + 8'(i));
    t = 0;
    while (acc_n < base + 2 && t < 100) begin @(posedge clk); t++; end
    chk("mid_pkt_reached", 32'(acc_n - base), 2);
    #2 m_ready = 0;
    @(negedge clk); #1 rst = 0; #1;
    chk("async_rd_en", 32'(rd_en), 0);
    chk("async_valid", 32'(m_valid), 0);
    chk("async_data", 32'(m_data), 0);
    chk("async_last", 32'(m_last), 0);
    chk("async_count", 32'(wc), 0);
    chk("async_busy", 32'(busy), 0);
    fq.delete(); pushed = popped; exp_q.delete(); pidx = 0; rd_n = 0; acc_n = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1; m_ready = 1;
    for (int i = 0; i < 4; i++) push_m(8'h20 + 8'(i));
    drain();
    chk("count_after_rst", 32'(wc), 4);
    // narrow counter wrap with single-beat packets
    @(posedge clk); #2;
    for (int i = 0; i < 17; i++) push_w(8'($urandom));
    drain();
    chk("wrap_count", 32'(wc_w), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
